riscv_mem_arbiter: RTL
======================

RISCV_MEM_ARBITER -- requirements
Module: riscv_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all ports.
REQ-002 Parameter DATA_W, default 32, data width of all ports; byte-enable width is DATA_W/8.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 instr_req_i  input  1  fetch request; held until instr_gnt_o.
REQ-006 instr_addr_i  input  ADDR_W  fetch address; stable while instr_req_i high.
REQ-007 instr_gnt_o  output  1  fetch request accepted this cycle.
REQ-008 instr_rvalid_o  output  1  fetch response valid, one-cycle pulse.
REQ-009 instr_rdata_o  output  DATA_W  fetched instruction.
REQ-010 data_req_i  input  1  load/store request; held until data_gnt_o.
REQ-011 data_we_i  input  1  1 = store, 0 = load.
REQ-012 data_be_i  input  DATA_W/8  store byte enables.
REQ-013 data_addr_i  input  ADDR_W  load/store address.
REQ-014 data_wdata_i  input  DATA_W  store data.
REQ-015 data_gnt_o  output  1  load/store accepted this cycle.
REQ-016 data_rvalid_o  output  1  load data or store acknowledge, one-cycle pulse.
REQ-017 data_rdata_o  output  DATA_W  load data.
REQ-018 mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o  outputs  1/1/DATA_W/8/ADDR_W/DATA_W  shared single-port memory request.
REQ-019 mem_gnt_i  input  1  memory accepted request.
REQ-020 mem_rvalid_i, mem_rdata_i  inputs  1/DATA_W  memory response; arrives at least 1 cycle after the grant.
REQ-021 err_o  output  1  sticky protocol-error flag.

Function
REQ-022 FSM states: IDLE, BUSY_I, BUSY_D; at most one outstanding memory transaction.
REQ-023 IDLE: mem_req_o = selected requester's req; mem_we/be/addr/wdata are muxed from the selected requester (mem_we_o = 0 and mem_be_o = all-ones for fetch).
REQ-024 Selection with a single requester: that requester is selected.
REQ-025 Selection with both requesting and no lock: the requester not granted most recently is selected (round-robin); last_grant resets to DATA, so fetch wins the first tie.
REQ-026 Lock: once mem_req_o is high without mem_gnt_i, the selection is held (sel_lock register) until the grant; a newly arriving request cannot steal the slot.
REQ-027 Grant: in IDLE, mem_req_o & mem_gnt_i asserts the selected gnt_o in the same cycle (combinational), updates last_grant, clears the lock, and moves to BUSY_I or BUSY_D.
REQ-028 BUSY_x: mem_req_o, instr_gnt_o and data_gnt_o are 0.
REQ-029 BUSY_x with mem_rvalid_i: x_rvalid_o = 1 in the same cycle and the FSM returns to IDLE; a new grant is possible the following cycle.
REQ-030 instr_rdata_o and data_rdata_o pass mem_rdata_i through combinationally; valid only when qualified by rvalid.
REQ-031 Latency added by the block: 0 cycles on request and on response; peak throughput is one transaction per 2 cycles.
REQ-032 Stores complete with data_rvalid_o like loads.
REQ-033 Starvation bound: a held request is granted after at most one transaction of the other requester.
REQ-034 mem_rvalid_i while in IDLE sets err_o and produces no rvalid_o; err_o clears only on reset.
REQ-035 mem_gnt_i while mem_req_o = 0 is ignored.

Reset
REQ-036 When reset_n = 0 at a clk edge: state = IDLE, last_grant = DATA, sel_lock cleared, err_o = 0.
REQ-037 During and after reset, all gnt_o/rvalid_o are 0 until the next legal event; mem_req_o follows REQ-023 from the first cycle after reset.
REQ-038 Reset mid-transaction drops the outstanding response; the memory is reset concurrently.

Structure
REQ-039 riscv_pkg holds the arb_state_e enum (IDLE/BUSY_I/BUSY_D) and the requester_e enum (REQ_INSTR/REQ_DATA).
REQ-040 Two-way round-robin selection (REQ-024 to REQ-026) is a sub-module: riscv_rr_arb2.

Verification
REQ-041 Fetch only: instr_req_i = 1, addr 0x100, mem_gnt_i = 1, rvalid 2 cycles later with 0x00500093 -> instr_gnt_o in cycle 0, instr_rvalid_o pulse with rdata 0x00500093, data_* silent.
REQ-042 Simultaneous fetch 0x200 and load 0x1000 after reset, memory always grants -> fetch granted first, load granted on the first IDLE cycle after the fetch rvalid; then alternation continues while both are held.
REQ-043 Lock: fetch requested, mem_gnt_i = 0 for 3 cycles, data_req_i rises in cycle 1 -> mem_addr_o stays 0x200 until the grant; data is served next.
REQ-044 Store 0xDEADBEEF, be 4'b0011, addr 0x2004 -> mem_we_o = 1, mem_be_o = 0011, mem_wdata_o passes through, data_rvalid_o acknowledges.
REQ-045 Spurious mem_rvalid_i in IDLE -> err_o = 1 and held; reset_n = 0 for one cycle -> err_o = 0.
REQ-046 Reset asserted in BUSY_D, then a late mem_rvalid_i -> no data_rvalid_o, FSM in IDLE, err_o set per REQ-034.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types for the instruction/data memory arbiter.
//   arb_state_e : arbiter FSM state (idle or one outstanding fetch/data access)
//   requester_e : identity of the requester owning the memory port
//   other_req() : returns the requester opposite to the one given
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_INSTR = 1'b0,
    REQ_DATA  = 1'b1
  } requester_e;

  function automatic requester_e other_req(input requester_e r);
    other_req = (r == REQ_INSTR) ? REQ_DATA : REQ_INSTR;
  endfunction

endpackage

// File: rtl/riscv_rr_arb2.sv
// Two-way round-robin selector with request lock.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   instr_req    : fetch requester is requesting
//   data_req     : load/store requester is requesting
//   hold         : memory request pending without grant this cycle (lock selection)
//   grant        : memory request granted this cycle
//   sel          : currently selected requester (combinational)
module riscv_rr_arb2
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       instr_req,
  input  logic       data_req,
  input  logic       hold,
  input  logic       grant,
  output requester_e sel
);

  requester_e last_grant_r;
  requester_e lock_sel_r;
  logic       lock_r;

  // Selection: a locked choice wins, then round-robin on a tie, then the lone requester.
  always_comb begin
    sel = REQ_INSTR;
    if (lock_r) begin
      sel = lock_sel_r;
    end else if (instr_req && data_req) begin
      sel = other_req(last_grant_r);
    end else if (data_req) begin
      sel = REQ_DATA;
    end else begin
      sel = REQ_INSTR;
    end
  end

  // Track the last granted requester and freeze the selection while a request waits.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant_r <= REQ_DATA;
      lock_r       <= 1'b0;
      lock_sel_r   <= REQ_INSTR;
    end else if (grant) begin
      last_grant_r <= sel;
      lock_r       <= 1'b0;
    end else if (hold) begin
      lock_r       <= 1'b1;
      lock_sel_r   <= sel;
    end else begin
      lock_r       <= 1'b0;
    end
  end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Arbitrates a fetch port and a load/store port onto one single-port memory,
// with at most one outstanding memory transaction and zero added latency.
// Ports:
//   clk, reset_n                       : clock, synchronous active-low reset
//   instr_req_i/addr_i, instr_gnt_o    : fetch request handshake
//   instr_rvalid_o/rdata_o             : fetch response
//   data_req_i/we_i/be_i/addr_i/wdata_i: load/store request
//   data_gnt_o, data_rvalid_o/rdata_o  : load/store handshake and response
//   mem_req_o/we_o/be_o/addr_o/wdata_o : shared memory request
//   mem_gnt_i, mem_rvalid_i/rdata_i    : memory grant and response
//   err_o                              : sticky flag, response seen with nothing outstanding
module riscv_mem_arbiter
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                instr_req_i,
  input  logic [ADDR_W-1:0]   instr_addr_i,
  output logic                instr_gnt_o,
  output logic                instr_rvalid_o,
  output logic [DATA_W-1:0]   instr_rdata_o,
  input  logic                data_req_i,
  input  logic                data_we_i,
  input  logic [DATA_W/8-1:0] data_be_i,
  input  logic [ADDR_W-1:0]   data_addr_i,
  input  logic [DATA_W-1:0]   data_wdata_i,
  output logic                data_gnt_o,
  output logic                data_rvalid_o,
  output logic [DATA_W-1:0]   data_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                err_o
);

  arb_state_e state_r;
  arb_state_e state_next_s;
  requester_e sel_s;
  logic       sel_instr_s;
  logic       grant_s;
  logic       hold_s;
  logic       err_r;

  riscv_rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .reset_n   (reset_n),
    .instr_req (instr_req_i),
    .data_req  (data_req_i),
    .hold      (hold_s),
    .grant     (grant_s),
    .sel       (sel_s)
  );

  assign sel_instr_s = (sel_s == REQ_INSTR);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state: grant opens a transaction, the memory response closes it.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_s) begin
          state_next_s = sel_instr_s ? BUSY_I : BUSY_D;
        end else begin
          state_next_s = IDLE;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_rvalid_i) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = state_r;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Outputs: request mux in IDLE, response steering in BUSY; all quiet during reset.
  always_comb begin
    mem_req_o = 1'b0;
    if (reset_n && (state_r == IDLE)) begin
      mem_req_o = sel_instr_s ? instr_req_i : data_req_i;
    end else begin
      mem_req_o = 1'b0;
    end
    mem_we_o       = sel_instr_s ? 1'b0 : data_we_i;
    mem_be_o       = sel_instr_s ? {(DATA_W/8){1'b1}} : data_be_i;
    mem_addr_o     = sel_instr_s ? instr_addr_i : data_addr_i;
    mem_wdata_o    = sel_instr_s ? {DATA_W{1'b0}} : data_wdata_i;
    // mem_req_o is already qualified by IDLE, so a stray grant is ignored.
    grant_s        = mem_req_o & mem_gnt_i;
    hold_s         = mem_req_o & ~mem_gnt_i;
    instr_gnt_o    = grant_s & sel_instr_s;
    data_gnt_o     = grant_s & ~sel_instr_s;
    instr_rvalid_o = reset_n & (state_r == BUSY_I) & mem_rvalid_i;
    data_rvalid_o  = reset_n & (state_r == BUSY_D) & mem_rvalid_i;
    instr_rdata_o  = mem_rdata_i;
    data_rdata_o   = mem_rdata_i;
  end

  // Sticky error: a memory response with nothing outstanding.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_r <= 1'b0;
    end else if ((state_r == IDLE) && mem_rvalid_i) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err_o = err_r;

endmodule
